// File: rtl/thresholding_cfg_loader_pkg.sv
// Shared types and width helpers for the thresholding configuration loader.
package thresholding_cfg_loader_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   typedef enum logic {LOAD = 1'b0, VERIFY = 1'b1} mode_e;

   // Counters need at least one bit even when their field collapses to zero width.
   function automatic int fld_w(input int n);
      int w;
      w = $clog2(n);
      return (w > 1) ? w : 1;
   endfunction

   function automatic int addr_w(input int n, input int c, input int pe, input int sets);
      return $clog2(n) + $clog2(pe) + $clog2(c / pe) + $clog2(sets);
   endfunction

endpackage

// File: rtl/cfg_loader_exp_fifo.sv
// Synchronous FIFO holding {address, expected value} for in-flight readbacks.
module cfg_loader_exp_fifo
   import thresholding_cfg_loader_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = fld_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/thresholding_cfg_loader.sv
// Streams threshold values into a thresholding instance's cfg port, either
// writing them (LOAD) or reading back and comparing (VERIFY).
module thresholding_cfg_loader
   import thresholding_cfg_loader_pkg::*;
#(
   parameter int K          = 8,
   parameter int N          = 3,
   parameter int C          = 4,
   parameter int PE         = 2,
   parameter int SETS       = 1,
   parameter int EXP_DEPTH  = 8,
   parameter int RB_TIMEOUT = 64,
   localparam int A         = addr_w(N, C, PE, SETS)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [15:0]  err_cnt,
   output logic [A-1:0] err_addr,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic [K-1:0] s_tdata,
   output logic         cfg_en,
   output logic         cfg_we,
   output logic [A-1:0] cfg_a,
   output logic [K-1:0] cfg_d,
   input  logic         cfg_rack,
   input  logic [K-1:0] cfg_q
);

   localparam int CF = C / PE;
   localparam int LN = $clog2(N);
   localparam int LP = $clog2(PE);
   localparam int LC = $clog2(CF);
   localparam int IW = fld_w(N);
   localparam int PW = fld_w(PE);
   localparam int FW = fld_w(CF);
   localparam int SW = fld_w(SETS);
   localparam int TW = $clog2(RB_TIMEOUT + 1);
   localparam logic [IW-1:0] I_LAST   = IW'(N - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(PE - 1);
   localparam logic [FW-1:0] F_LAST   = FW'(CF - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(SETS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(RB_TIMEOUT - 1);

   state_e        state;
   mode_e         mode_q;
   logic [IW-1:0] i_q;
   logic [PW-1:0] pe_q;
   logic [FW-1:0] cf_q;
   logic [SW-1:0] s_q;
   logic          all_issued;
   logic [TW-1:0] tmo;
   logic [A-1:0]  addr;
   logic          accept;
   logic          last_beat;
   logic          begin_pass;
   logic          rb_active;
   logic          mismatch;
   logic          timeout;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [A+K-1:0] fifo_dout;
   logic [A-1:0]  exp_a;
   logic [K-1:0]  exp_d;

   // Zero-width fields hold a constant 0 counter, so shifting them in is harmless.
   assign addr = (A'(s_q) << (LC + LP + LN)) | (A'(cf_q) << (LP + LN))
               | (A'(pe_q) << LN) | A'(i_q);

   assign s_tready   = (state == RUN) && !all_issued && (mode_q == LOAD || !fifo_full);
   assign accept     = s_tvalid && s_tready;
   assign last_beat  = (i_q == I_LAST) && (pe_q == P_LAST) && (cf_q == F_LAST) && (s_q == S_LAST);
   assign begin_pass = (state == IDLE) && start;
   assign rb_active  = (state == RUN || state == DRAIN) && (mode_q == VERIFY);
   assign fifo_push  = accept && (mode_q == VERIFY);
   assign fifo_pop   = rb_active && cfg_rack && !fifo_empty;
   assign {exp_a, exp_d} = fifo_dout;
   assign mismatch   = fifo_pop && (cfg_q != exp_d);
   assign timeout    = (state == DRAIN) && !fifo_empty && !cfg_rack && (tmo == TMO_LAST);

   cfg_loader_exp_fifo #(.DEPTH(EXP_DEPTH), .W(A + K)) u_exp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (begin_pass),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({addr, s_tdata}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_q <= LOAD;
         busy   <= 1'b0;
         done   <= 1'b0;
         tmo    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               state  <= RUN;
               mode_q <= mode_e'(mode);
               busy   <= 1'b1;
            end
            RUN: if (all_issued) begin
               if (mode_q == VERIFY) begin
                  state <= DRAIN;
                  tmo   <= '0;
               end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DRAIN: if (fifo_empty || timeout) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else if (cfg_rack) begin
               tmo <= '0;
            end else begin
               tmo <= tmo + TW'(1);
            end
            DONE: state <= IDLE;
         endcase
      end
   end

   // Nested beat counters: index, then PE row, then channel fold, then set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q        <= '0;
         pe_q       <= '0;
         cf_q       <= '0;
         s_q        <= '0;
         all_issued <= 1'b0;
      end else if (begin_pass) begin
         i_q        <= '0;
         pe_q       <= '0;
         cf_q       <= '0;
         s_q        <= '0;
         all_issued <= 1'b0;
      end else if (accept) begin
         if (last_beat) all_issued <= 1'b1;
         if (i_q != I_LAST) begin
            i_q <= i_q + IW'(1);
         end else begin
            i_q <= '0;
            if (pe_q != P_LAST) begin
               pe_q <= pe_q + PW'(1);
            end else begin
               pe_q <= '0;
               if (cf_q != F_LAST) begin
                  cf_q <= cf_q + FW'(1);
               end else begin
                  cf_q <= '0;
                  s_q  <= (s_q == S_LAST) ? '0 : s_q + SW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_en <= 1'b0;
         cfg_we <= 1'b0;
         cfg_a  <= '0;
         cfg_d  <= '0;
      end else begin
         cfg_en <= accept;
         cfg_we <= accept && (mode_q == LOAD);
         cfg_a  <= accept ? addr : '0;
         cfg_d  <= (accept && mode_q == LOAD) ? s_tdata : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= 1'b0;
         err_cnt  <= '0;
         err_addr <= '0;
      end else if (begin_pass) begin
         err      <= 1'b0;
         err_cnt  <= '0;
         err_addr <= '0;
      end else begin
         if (timeout || mismatch || (rb_active && cfg_rack && fifo_empty)) err <= 1'b1;
         if (mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0)    err_addr <= exp_a;
         end
      end
   end

endmodule
